sram_port_arbiter: RTL and testbench

//  Shares one single-ported SRAM between the instruction-fetch requester (IF) and the

---
 rtl/sram_port_arbiter.sv | 104 ++++++++++
 tb/tb_sram_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported SRAM between IF and EX/MEM.
// Tags reads in flight and steers read data back to their owner.
module sram_port_arbiter #(
   parameter int LAT        = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        if_flush,
   input  logic        mem_req,
   input  logic [3:0]  mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_gnt,
   output logic        mem_rvalid,
   output logic [31:0] mem_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        stallreq
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0]  starve_cnt;
   logic           force_if;
   logic           rd_issue;
   logic [LAT-1:0] tag_v;
   logic [LAT-1:0] tag_o;
   logic           last_v;
   logic           last_o;

   // grant: MEM wins unless IF has been starved too long; gated off in reset
   always_comb begin
      force_if = if_req & (starve_cnt == CW'(STARVE_MAX));
      mem_gnt  = ~rst & mem_req & ~force_if;
      if_gnt   = ~rst & if_req & ~mem_gnt;
      stallreq = ~rst & ((if_req & ~if_gnt) | (mem_req & ~mem_gnt));
      rd_issue = if_gnt | (mem_gnt & (mem_wen == 4'b0000));
   end

   // SRAM port mux: granted requester drives the array, idle drives zeros
   always_comb begin
      sram_en    = if_gnt | mem_gnt;
      sram_wen   = 4'b0000;
      sram_addr  = 32'h0;
      sram_wdata = 32'h0;
      unique case (1'b1)
         mem_gnt: begin
            sram_wen   = mem_wen;
            sram_addr  = mem_addr;
            sram_wdata = mem_wdata;
         end
         if_gnt: begin
            sram_addr = if_addr;
         end
         default: ;
      endcase
   end

   // IF starvation counter, saturating at STARVE_MAX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (~if_req | if_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CW'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end

   // read tag pipe; a flush kills every IF-owned tag, including one entering
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_v <= '0;
         tag_o <= '0;
      end else begin
         tag_v[0] <= rd_issue & ~(if_flush & ~mem_gnt);
         tag_o[0] <= mem_gnt;
         for (int i = 1; i < LAT; i++) begin
            tag_v[i] <= tag_v[i-1] & ~(if_flush & ~tag_o[i-1]);
            tag_o[i] <= tag_o[i-1];
         end
      end
   end

   // return path: the oldest tag selects who sees sram_rdata this cycle
   always_comb begin
      last_v     = tag_v[LAT-1];
      last_o     = tag_o[LAT-1];
      if_rvalid  = ~rst & last_v & ~last_o & ~if_flush;
      mem_rvalid = ~rst & last_v & last_o;
      if_rdata   = if_rvalid  ? sram_rdata : 32'h0;
      mem_rdata  = mem_rvalid ? sram_rdata : 32'h0;
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of arbitration, tagging and flush.
// Instance a uses LAT=1, instance b uses LAT=3, each with its own SRAM model.
module tb_sram_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic        rst_a, if_req_a, if_gnt_a, if_rv_a, if_fl_a;
   logic        mem_req_a, mem_gnt_a, mem_rv_a, sen_a, stall_a;
   logic [3:0]  mem_wen_a, swen_a;
   logic [31:0] if_addr_a, if_rd_a, mem_addr_a, mem_wd_a, mem_rd_a;
   logic [31:0] saddr_a, swd_a, srd_a;

   logic        rst_b, if_req_b, if_gnt_b, if_rv_b, if_fl_b;
   logic        mem_req_b, mem_gnt_b, mem_rv_b, sen_b, stall_b;
   logic [3:0]  mem_wen_b, swen_b;
   logic [31:0] if_addr_b, if_rd_b, mem_addr_b, mem_wd_b, mem_rd_b;
   logic [31:0] saddr_b, swd_b, srd_b;

   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   logic [31:0] pa0, pb0, pb1, pb2;

   sram_port_arbiter #(.LAT(1), .STARVE_MAX(3)) dut_a (
      .clk(clk), .rst(rst_a),
      .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
      .if_rvalid(if_rv_a), .if_rdata(if_rd_a), .if_flush(if_fl_a),
      .mem_req(mem_req_a), .mem_wen(mem_wen_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wd_a), .mem_gnt(mem_gnt_a), .mem_rvalid(mem_rv_a),
      .mem_rdata(mem_rd_a), .sram_en(sen_a), .sram_wen(swen_a),
      .sram_addr(saddr_a), .sram_wdata(swd_a), .sram_rdata(srd_a),
      .stallreq(stall_a)
   );

   sram_port_arbiter #(.LAT(3), .STARVE_MAX(3)) dut_b (
      .clk(clk), .rst(rst_b),
      .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
      .if_rvalid(if_rv_b), .if_rdata(if_rd_b), .if_flush(if_fl_b),
      .mem_req(mem_req_b), .mem_wen(mem_wen_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wd_b), .mem_gnt(mem_gnt_b), .mem_rvalid(mem_rv_b),
      .mem_rdata(mem_rd_b), .sram_en(sen_b), .sram_wen(swen_b),
      .sram_addr(saddr_b), .sram_wdata(swd_b), .sram_rdata(srd_b),
      .stallreq(stall_b)
   );

   // SRAM model, LAT=1
   always @(posedge clk) begin
      if (sen_a && swen_a == 4'b0000) pa0 <= mem_a[saddr_a[9:2]];
      for (int b = 0; b < 4; b++)
         if (sen_a && swen_a[b]) mem_a[saddr_a[9:2]][8*b +: 8] <= swd_a[8*b +: 8];
   end
   assign srd_a = pa0;

   // SRAM model, LAT=3
   always @(posedge clk) begin
      if (sen_b && swen_b == 4'b0000) pb0 <= mem_b[saddr_b[9:2]];
      pb1 <= pb0;
      pb2 <= pb1;
      for (int b = 0; b < 4; b++)
         if (sen_b && swen_b[b]) mem_b[saddr_b[9:2]][8*b +: 8] <= swd_b[8*b +: 8];
   end
   assign srd_b = pb2;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      if_req_a = 0; if_addr_a = 0; if_fl_a = 0;
      mem_req_a = 0; mem_wen_a = 0; mem_addr_a = 0; mem_wd_a = 0;
      if_req_b = 0; if_addr_b = 0; if_fl_b = 0;
      mem_req_b = 0; mem_wen_b = 0; mem_addr_b = 0; mem_wd_b = 0;
   endtask

   task automatic test_reset();
      if_req_a = 1; mem_req_a = 1; if_req_b = 1; mem_req_b = 1;
      #1;
      n_cmp++;
      if ({if_gnt_a, mem_gnt_a, sen_a, stall_a} !== 4'b0) begin
         n_bad++;
         $display("FAIL rst_a_outs got %b want 0000",
                  {if_gnt_a, mem_gnt_a, sen_a, stall_a});
      end
      n_cmp++;
      if ({if_gnt_b, mem_gnt_b, sen_b, stall_b, if_rv_b, mem_rv_b} !== 6'b0) begin
         n_bad++;
         $display("FAIL rst_b_outs got %b want 000000",
                  {if_gnt_b, mem_gnt_b, sen_b, stall_b, if_rv_b, mem_rv_b});
      end
      cyc();
      rst_a = 0; rst_b = 0;
      idle_all();
      cyc();
   endtask

   task automatic test_if_stream();
      logic [31:0] exp_d [3];
      exp_d[0] = 32'hC0DE0000;
      exp_d[1] = 32'hC0DE0001;
      exp_d[2] = 32'hC0DE0002;
      for (int k = 0; k < 4; k++) begin
         if_req_a  = (k < 3);
         if_addr_a = 32'(k * 4);
         #1;
         if (k < 3) begin
            n_cmp++;
            if ({if_gnt_a, stall_a, sen_a} !== 3'b101 || saddr_a !== 32'(k * 4)) begin
               n_bad++;
               $display("FAIL if_gnt_%0d got gnt/stall/en=%b addr=%h want 101 addr=%h",
                        k, {if_gnt_a, stall_a, sen_a}, saddr_a, 32'(k * 4));
            end
         end
         if (k > 0) begin
            n_cmp++;
            if (if_rv_a !== 1'b1 || if_rd_a !== exp_d[k-1]) begin
               n_bad++;
               $display("FAIL if_data_%0d got v=%b d=%h want v=1 d=%h",
                        k, if_rv_a, if_rd_a, exp_d[k-1]);
            end
         end
         cyc();
      end
      idle_all();
      #1;
      n_cmp++;
      if (if_rv_a !== 1'b0) begin
         n_bad++;
         $display("FAIL if_tail got %b want 0", if_rv_a);
      end
      cyc();
   endtask

   task automatic test_conflict();
      if_req_a = 1; if_addr_a = 32'h10;
      mem_req_a = 1; mem_wen_a = 0; mem_addr_a = 32'h100;
      #1;
      n_cmp++;
      if ({mem_gnt_a, if_gnt_a, stall_a} !== 3'b101 || saddr_a !== 32'h100) begin
         n_bad++;
         $display("FAIL conflict_gnt got m/i/s=%b addr=%h want 101 addr=100",
                  {mem_gnt_a, if_gnt_a, stall_a}, saddr_a);
      end
      cyc();
      idle_all();
      #1;
      n_cmp++;
      if (mem_rv_a !== 1'b1 || mem_rd_a !== 32'hC0DE0040 ||
          if_rv_a !== 1'b0 || if_rd_a !== 32'h0) begin
         n_bad++;
         $display("FAIL conflict_ret got mv=%b md=%h iv=%b id=%h want 1 c0de0040 0 0",
                  mem_rv_a, mem_rd_a, if_rv_a, if_rd_a);
      end
      cyc();
   endtask

   task automatic test_starve();
      logic [5:0] exp_m;
      exp_m = 6'b110111;
      if_req_a = 1; if_addr_a = 32'h40;
      mem_req_a = 1; mem_wen_a = 4'hF; mem_wd_a = 32'h5555_0000;
      for (int k = 0; k < 6; k++) begin
         mem_addr_a = 32'h300 + 32'(k * 4);
         #1;
         n_cmp++;
         if (mem_gnt_a !== exp_m[k] || if_gnt_a !== ~exp_m[k] || stall_a !== 1'b1) begin
            n_bad++;
            $display("FAIL starve_%0d got m/i/s=%b%b%b want %b%b1",
                     k, mem_gnt_a, if_gnt_a, stall_a, exp_m[k], ~exp_m[k]);
         end
         if (k == 3) begin
            n_cmp++;
            if (swen_a !== 4'b0 || saddr_a !== 32'h40 || swd_a !== 32'h0) begin
               n_bad++;
               $display("FAIL starve_drive got wen=%b a=%h wd=%h want 0 40 0",
                        swen_a, saddr_a, swd_a);
            end
         end
         if (k == 4) begin
            n_cmp++;
            if (if_rv_a !== 1'b1 || if_rd_a !== 32'hC0DE0010) begin
               n_bad++;
               $display("FAIL starve_ret got v=%b d=%h want 1 c0de0010", if_rv_a, if_rd_a);
            end
         end
         cyc();
      end
      idle_all();
      cyc();
   endtask

   task automatic test_store_load();
      mem_req_a = 1; mem_wen_a = 4'b0011; mem_addr_a = 32'h200; mem_wd_a = 32'hAABBCCDD;
      #1;
      n_cmp++;
      if (mem_gnt_a !== 1'b1 || swen_a !== 4'b0011 || swd_a !== 32'hAABBCCDD ||
          saddr_a !== 32'h200) begin
         n_bad++;
         $display("FAIL store_drive got g=%b wen=%b wd=%h a=%h want 1 0011 aabbccdd 200",
                  mem_gnt_a, swen_a, swd_a, saddr_a);
      end
      cyc();
      mem_wen_a = 4'b0000; mem_wd_a = 0;
      #1;
      n_cmp++;
      if (mem_rv_a !== 1'b0 || swen_a !== 4'b0000 || mem_gnt_a !== 1'b1) begin
         n_bad++;
         $display("FAIL store_norv got rv=%b wen=%b g=%b want 0 0000 1",
                  mem_rv_a, swen_a, mem_gnt_a);
      end
      cyc();
      idle_all();
      #1;
      n_cmp++;
      if (mem_rv_a !== 1'b1 || mem_rd_a !== 32'hC0DECCDD) begin
         n_bad++;
         $display("FAIL load_back got v=%b d=%h want 1 c0deccdd", mem_rv_a, mem_rd_a);
      end
      cyc();
   endtask

   task automatic test_flush();
      if_req_b = 1; if_addr_b = 32'h0;
      cyc();
      if_addr_b = 32'h4;
      cyc();
      if_req_b = 0; if_fl_b = 1;
      cyc();
      if_fl_b = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (if_rv_b !== 1'b0 || if_rd_b !== 32'h0) begin
            n_bad++;
            $display("FAIL flush_if_%0d got v=%b d=%h want 0 0", k, if_rv_b, if_rd_b);
         end
         cyc();
      end
      if_req_b = 1; if_addr_b = 32'h8;
      cyc();
      if_req_b = 0; mem_req_b = 1; mem_wen_b = 0; mem_addr_b = 32'h100;
      #1;
      n_cmp++;
      if (mem_gnt_b !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_mgnt got %b want 1", mem_gnt_b);
      end
      cyc();
      mem_req_b = 0; if_fl_b = 1;
      cyc();
      if_fl_b = 0;
      #1;
      n_cmp++;
      if (if_rv_b !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_if_mix got %b want 0", if_rv_b);
      end
      cyc();
      #1;
      n_cmp++;
      if (mem_rv_b !== 1'b1 || mem_rd_b !== 32'hC0DE0040) begin
         n_bad++;
         $display("FAIL flush_mem_ret got v=%b d=%h want 1 c0de0040", mem_rv_b, mem_rd_b);
      end
      cyc();
      if_req_b = 1; if_addr_b = 32'hC;
      cyc();
      if_req_b = 0;
      cyc();
      cyc();
      if_fl_b = 1;
      #1;
      n_cmp++;
      if (if_rv_b !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_comb got %b want 0", if_rv_b);
      end
      if_fl_b = 0;
      #1;
      n_cmp++;
      if (if_rv_b !== 1'b1 || if_rd_b !== 32'hC0DE0003) begin
         n_bad++;
         $display("FAIL flush_unmask got v=%b d=%h want 1 c0de0003", if_rv_b, if_rd_b);
      end
      cyc();
      idle_all();
      cyc();
   endtask

   task automatic test_async_reset();
      if_req_b = 1; if_addr_b = 32'h10;
      cyc();
      if_addr_b = 32'h14;
      cyc();
      if_addr_b = 32'h18;
      #1;
      n_cmp++;
      if (if_gnt_b !== 1'b1) begin
         n_bad++;
         $display("FAIL arst_pre got %b want 1", if_gnt_b);
      end
      rst_b = 1;
      #1;
      n_cmp++;
      if ({if_gnt_b, sen_b, stall_b, if_rv_b, mem_rv_b} !== 5'b0 || saddr_b !== 32'h0) begin
         n_bad++;
         $display("FAIL arst_now got %b a=%h want 00000 0",
                  {if_gnt_b, sen_b, stall_b, if_rv_b, mem_rv_b}, saddr_b);
      end
      cyc();
      rst_b = 0; if_req_b = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_cmp++;
         if (if_rv_b !== 1'b0 || mem_rv_b !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_quiet_%0d got iv=%b mv=%b want 0 0", k, if_rv_b, mem_rv_b);
         end
         cyc();
      end
      if_req_b = 1; if_addr_b = 32'h20;
      cyc();
      if_req_b = 0;
      cyc();
      cyc();
      #1;
      n_cmp++;
      if (if_rv_b !== 1'b1 || if_rd_b !== 32'hC0DE0008) begin
         n_bad++;
         $display("FAIL arst_new got v=%b d=%h want 1 c0de0008", if_rv_b, if_rd_b);
      end
      cyc();
   endtask

   initial begin
      rst_a = 1; rst_b = 1;
      pa0 = 0; pb0 = 0; pb1 = 0; pb2 = 0;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = {16'hC0DE, 16'(i)};
         mem_b[i] = {16'hC0DE, 16'(i)};
      end
      idle_all();
      test_reset();
      test_if_stream();
      test_conflict();
      test_starve();
      test_store_load();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
